// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding and FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads and lane merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = lane[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data  = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        store_data = word;
        store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        store_data = word;
        store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-wide memory without byte enables.
// Define LSU_MISALIGN_ERR_EN to turn misaligned half/word accesses into errors.
//
// state    | meaning
// IDLE     | ready for a request
// LOAD     | word address driven, read data captured at the edge
// RMW_READ | word read ahead of a sub-word store
// WRITE    | single-cycle write of the merged word
// RESP     | one-cycle response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  lsu_state_e state, state_nxt;
  lsu_size_e  req_size_e, size_q;
  logic [31:0] addr_fix, addr_q, wdata_q, word_q;
  logic [31:0] load_data, store_data;
  logic        req_bad, accept;
  logic        write_q, unsigned_q, err_q;

  assign req_size_e = lsu_size_e'(req_size);
  assign accept     = req_valid && (state == IDLE);

  always_comb begin
    addr_fix = req_addr;
    req_bad  = (req_size_e == SIZE_RSVD) || (req_addr[31:2] >= 30'(MEM_WORDS));
`ifdef LSU_MISALIGN_ERR_EN
    if ((req_size_e == SIZE_HALF && req_addr[0]) ||
        (req_size_e == SIZE_WORD && req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
`else
    if (req_size_e == SIZE_HALF)
      addr_fix[0] = 1'b0;
    else if (req_size_e == SIZE_WORD)
      addr_fix[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)
            state_nxt = RESP;
          else if (!req_write)
            state_nxt = LOAD;
          else if (req_size_e == SIZE_WORD)
            state_nxt = WRITE;
          else
            state_nxt = RMW_READ;
        end
      end
      LOAD:     state_nxt = RESP;
      RMW_READ: state_nxt = WRITE;
      WRITE:    state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so the requester may move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SIZE_BYTE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      if (accept) begin
        addr_q     <= addr_fix;
        wdata_q    <= req_wdata;
        size_q     <= req_size_e;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        err_q      <= req_bad;
      end
      if (state == LOAD || state == RMW_READ)
        word_q <= mem_read_data;
    end
  end

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .lane        (addr_q[1:0]),
    .word        (word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Outputs decode from the state register, so reset clears them asynchronously.
  always_comb begin
    req_ready        = (state == IDLE);
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    resp_valid       = 1'b0;
    resp_err         = 1'b0;
    resp_rdata       = '0;
    case (state)
      LOAD, RMW_READ: mem_address = {addr_q[31:2], 2'b00};
      WRITE: begin
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_data   = store_data;
        mem_write_enable = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !write_q)
          resp_rdata = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 64-word behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64];
  int          wr_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_enable && mem_address < 32'd256) begin
      mem[mem_address[7:2]] <= mem_write_data;
      wr_count   <= wr_count + 1;
      last_waddr <= mem_address;
      last_wdata <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issues one request, scrambles req_* after acceptance, and measures latency.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int writes);
    int w0;
    @(negedge clk);
    check("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    w0 = wr_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wd;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_seen", {31'h0, resp_valid}, 32'h1);
    rdata  = resp_rdata;
    err    = resp_err;
    writes = wr_count - w0;
    @(posedge clk);
    #1;
    check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nw;

  initial begin
    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    check("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, nw);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_writes", 32'(nw), 32'd1);
    check("sw_waddr", last_waddr, 32'h10);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", {31'h0, er}, 32'h0);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nw);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'h0, er}, 32'h0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_writes", 32'(nw), 32'd0);

    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, rd, er, lat, nw);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_writes", 32'(nw), 32'd1);
    check("sb_waddr", last_waddr, 32'h10);
    check("sb_wdata", last_wdata, 32'hDEAD55EF);

    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat, nw);
    check("lb_13", rd, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, nw);
    check("lbu_13", rd, 32'h000000DE);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat, nw);
    check("lb_11", rd, 32'h00000055);
    check("lb_lat", 32'(lat), 32'd2);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, er, lat, nw);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, rd, er, lat, nw);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_wdata", last_wdata, 32'h80013344);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, nw);
    check("lh_12", rd, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat, nw);
    check("lhu_12", rd, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat, nw);
    check("lh_10", rd, 32'h00003344);

    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat, nw);
    check("oob_ld_err", {31'h0, er}, 32'h1);
    check("oob_ld_lat", 32'(lat), 32'd1);
    check("oob_ld_rdata", rd, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, rd, er, lat, nw);
    check("oob_st_err", {31'h0, er}, 32'h1);
    check("oob_st_writes", 32'(nw), 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, rd, er, lat, nw);
    check("rsvd_err", {31'h0, er}, 32'h1);
    check("rsvd_lat", 32'(lat), 32'd1);
    check("rsvd_writes", 32'(nw), 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, er, lat, nw);
`ifdef LSU_MISALIGN_ERR_EN
    check("mis_lw_err", {31'h0, er}, 32'h1);
    check("mis_lw_rdata", rd, 32'h0);
    check("mis_lw_lat", 32'(lat), 32'd1);
`else
    check("mis_lw_err", {31'h0, er}, 32'h0);
    check("mis_lw_rdata", rd, 32'h80013344);
    check("mis_lw_lat", 32'(lat), 32'd2);
`endif

    // Reset in the middle of a byte store's write cycle.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat, nw);
    nw = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_we_high", {31'h0, mem_write_enable}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_we_drop", {31'h0, mem_write_enable}, 32'h0);
    check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_late_resp", {31'h0, resp_valid}, 32'h0);
    end
    check("abort_no_write", 32'(wr_count - nw), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, nw);
    check("abort_word_kept", rd, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached memory.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-005 SHALL have ports req_write in 1, req_size in 2 (00 byte, 01 half, 10 word, 11 reserved), req_unsigned in 1, req_addr in 32 (byte address), req_wdata in 32.
REQ-006 SHALL have ports resp_valid out 1, resp_rdata out 32, resp_err out 1: response, no backpressure.
REQ-007 SHALL have ports mem_address out 32, mem_write_data out 32, mem_write_enable out 1, mem_read_data in 32: word-wide memory port, combinational read, write on clk edge, no byte enables.

Function
REQ-008 SHALL accept a request on the edge where req_valid && req_ready; req_ready SHALL be 1 only in IDLE.
REQ-009 SHALL register all req_* fields at acceptance; later changes to req_* SHALL not affect the transaction.
REQ-010 SHALL implement states IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-011 SHALL transition IDLE->LOAD for a legal load, IDLE->WRITE for a legal word store, IDLE->RMW_READ for a legal byte/half store, IDLE->RESP for an erroring request.
REQ-012 SHALL, in LOAD, drive mem_address = {addr[31:2],2'b00}, capture mem_read_data at the edge, then go to RESP.
REQ-013 SHALL extract the addressed byte/half from the captured word (little-endian, lane = addr[1:0]) and zero-extend if req_unsigned, else sign-extend, into resp_rdata.
REQ-014 SHALL, in RMW_READ, drive the word address, capture mem_read_data, then go to WRITE.
REQ-015 SHALL, in WRITE, assert mem_write_enable for exactly one cycle with mem_write_data = captured word with addressed lane(s) replaced by req_wdata[7:0] or [15:0] (word store: req_wdata unchanged), then go to RESP.
REQ-016 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE; stores SHALL return resp_rdata = 0.
REQ-017 SHALL report resp_err=1, with no memory access and resp_rdata=0, for req_size=11 or word index addr[31:2] >= MEM_WORDS.
REQ-018 SHALL give latency acceptance-edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-019 SHALL keep mem_write_enable 0 in every state except WRITE.

Reset
REQ-020 SHALL, while rst_n=0, force state IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_write_data=0, mem_write_enable=0.
REQ-021 SHALL abort any in-flight transaction on reset with no response and no further write; a write in WRITE SHALL be deasserted asynchronously.

Configuration
REQ-022 SHALL, with LSU_MISALIGN_ERR_EN defined, treat half access with addr[0]=1 or word access with addr[1:0]!=0 as an error per REQ-017.
REQ-023 SHALL, without LSU_MISALIGN_ERR_EN, force misaligned address low bits to zero (half: addr[0]=0; word: addr[1:0]=0) and proceed normally; misalignment SHALL never set resp_err.

Structure
REQ-024 SHALL place the req_size encoding typedef and the state enum in shared package lsu_pkg.
REQ-025 SHALL place lane extraction/sign extension and store merge in combinational sub-module lsu_align.

Verification
REQ-026 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> one write pulse at 0x10; load resp_rdata=0xDEADBEEF, resp_err=0, 2-cycle latencies.
REQ-027 Memory word 0x10=0xDEADBEEF; byte store 0x55 to 0x11 -> read then write 0xDEAD55EF; lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
REQ-028 Half store 0x8001 to 0x12 over 0x11223344 -> 0x80013344; lh 0x12 -> 0xFFFF8001; lhu -> 0x00008001.
REQ-029 Address 0x100 (MEM_WORDS=64) or req_size=11 -> resp_err=1 after 1 cycle, mem_write_enable never asserted.
REQ-030 Word load 0x13: with LSU_MISALIGN_ERR_EN -> resp_err=1; without -> data of 0x10, resp_err=0.
REQ-031 rst_n low during WRITE of a byte store -> mem_write_enable drops immediately, no resp_valid, req_ready=1 after release, target word unchanged.
